// File: rtl/ace_pkg.sv
// Shared ACE snoop types: AC snoop type, CR response bit layout and the
// snoop-broadcast FSM state encoding.
package ace_pkg;

    typedef logic [3:0] acsnoop_t;
    typedef logic [4:0] crresp_t;

    localparam int unsigned CrDataTransfer = 0;
    localparam int unsigned CrError        = 1;
    localparam int unsigned CrPassDirty    = 2;
    localparam int unsigned CrIsShared     = 3;
    localparam int unsigned CrWasUnique    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        RESP  = 2'd2
    } snoop_state_e;

endpackage

// File: rtl/ace_crresp_merge.sv
// Combinational merge of the CR responses accepted in one cycle: OR of all
// accepted responses and the lowest-index port reporting DataTransfer.
module ace_crresp_merge
    import ace_pkg::*;
#(
    parameter int unsigned NoSnoopPorts = 4,
    parameter int unsigned IdxWidth     = 2
) (
    input  logic [NoSnoopPorts-1:0]   fire_i,
    input  logic [5*NoSnoopPorts-1:0] resp_i,
    output crresp_t                   resp_o,
    output logic                      dt_any_o,
    output logic [IdxWidth-1:0]       dt_idx_o
);

    always_comb begin
        resp_o   = '0;
        dt_any_o = 1'b0;
        dt_idx_o = '0;
        // Walk from the top down so the lowest DataTransfer index wins.
        for (int i = NoSnoopPorts - 1; i >= 0; i--) begin
            if (fire_i[i]) begin
                resp_o = resp_o | resp_i[5*i +: 5];
                if (resp_i[5*i + CrDataTransfer]) begin
                    dt_any_o = 1'b1;
                    dt_idx_o = IdxWidth'(i);
                end
            end
        end
    end

endmodule

// File: rtl/ace_snoop_bcast.sv
// Broadcasts one snoop on the AC channel, gathers every CR response and returns
// one merged response. Optional snoop timeout with stale-port draining: ACE_SNOOP_TIMEOUT_EN.
module ace_snoop_bcast
    import ace_pkg::*;
#(
    parameter int unsigned NoSnoopPorts  = 4,
    parameter int unsigned AddrWidth     = 64,
    parameter bit          ExcludeSrc    = 1'b1,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned IdxWidth      = (NoSnoopPorts > 1) ? $clog2(NoSnoopPorts) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [AddrWidth-1:0]      req_addr_i,
    input  acsnoop_t                  req_snoop_i,
    input  logic [IdxWidth-1:0]       req_src_i,
    output logic [NoSnoopPorts-1:0]   ac_valid_o,
    input  logic [NoSnoopPorts-1:0]   ac_ready_i,
    output logic [AddrWidth-1:0]      ac_addr_o,
    output acsnoop_t                  ac_snoop_o,
    input  logic [NoSnoopPorts-1:0]   cr_valid_i,
    output logic [NoSnoopPorts-1:0]   cr_ready_o,
    input  logic [5*NoSnoopPorts-1:0] cr_resp_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output crresp_t                   rsp_resp_o,
    output logic                      rsp_data_vld_o,
    output logic [IdxWidth-1:0]       rsp_data_sel_o
);

    if (NoSnoopPorts < 1 || TimeoutCycles < 2) begin : g_bad_params
        $error("ace_snoop_bcast: NoSnoopPorts must be >= 1 and TimeoutCycles >= 2");
    end

    snoop_state_e             state_q, state_d;
    logic [AddrWidth-1:0]     addr_q, addr_d;
    acsnoop_t                 snoop_q, snoop_d;
    logic [NoSnoopPorts-1:0]  mask_q, mask_d, new_mask;
    logic [NoSnoopPorts-1:0]  ac_done_q, ac_done_d;
    logic [NoSnoopPorts-1:0]  cr_done_q, cr_done_d;
    crresp_t                  resp_q, resp_d;
    logic                     dvld_q, dvld_d;
    logic [IdxWidth-1:0]      dsel_q, dsel_d;
    logic [NoSnoopPorts-1:0]  ac_fire, cr_live;
    crresp_t                  merge_resp;
    logic                     merge_dt_any;
    logic [IdxWidth-1:0]      merge_dt_idx;

`ifdef ACE_SNOOP_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles) + 1;
    logic [CntWidth-1:0]      cnt_q, cnt_d;
    logic [NoSnoopPorts-1:0]  stale_ac_q, stale_ac_d;
    logic [NoSnoopPorts-1:0]  stale_cr_q, stale_cr_d;
`endif

    // Valid/ready: a transfer happens on any cycle where both are high at the
    // clock edge; a raised valid and its payload hold until that transfer.
    always_comb begin
        req_ready_o = (state_q == IDLE);
        ac_valid_o  = (state_q == SNOOP) ? (mask_q & ~ac_done_q) : '0;
        cr_ready_o  = (state_q == SNOOP) ? (ac_done_q & ~cr_done_q) : '0;
`ifdef ACE_SNOOP_TIMEOUT_EN
        // Timed-out ports finish their AC, then have their late CR swallowed.
        ac_valid_o  = ac_valid_o | stale_ac_q;
        cr_ready_o  = cr_ready_o | (stale_cr_q & ~stale_ac_q);
        req_ready_o = req_ready_o & (stale_ac_q == '0);
`endif
        ac_fire = ac_valid_o & ac_ready_i;
        cr_live = (state_q == SNOOP) ? (cr_valid_i & cr_ready_o & mask_q) : '0;
    end

    ace_crresp_merge #(
        .NoSnoopPorts (NoSnoopPorts),
        .IdxWidth     (IdxWidth)
    ) u_merge (
        .fire_i   (cr_live),
        .resp_i   (cr_resp_i),
        .resp_o   (merge_resp),
        .dt_any_o (merge_dt_any),
        .dt_idx_o (merge_dt_idx)
    );

    always_comb begin
        new_mask = '1;
        for (int i = 0; i < NoSnoopPorts; i++) begin
            if (ExcludeSrc && (req_src_i == IdxWidth'(i))) new_mask[i] = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        snoop_d   = snoop_q;
        mask_d    = mask_q;
        ac_done_d = ac_done_q;
        cr_done_d = cr_done_q;
        resp_d    = resp_q;
        dvld_d    = dvld_q;
        dsel_d    = dsel_q;
`ifdef ACE_SNOOP_TIMEOUT_EN
        cnt_d      = cnt_q;
        stale_ac_d = stale_ac_q & ~ac_fire;
        stale_cr_d = stale_cr_q & ~(cr_valid_i & cr_ready_o);
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_o) begin
                    addr_d    = req_addr_i;
                    snoop_d   = req_snoop_i;
                    mask_d    = new_mask;
`ifdef ACE_SNOOP_TIMEOUT_EN
                    mask_d    = new_mask & ~stale_cr_q;
                    cnt_d     = '0;
`endif
                    ac_done_d = '0;
                    cr_done_d = '0;
                    resp_d    = '0;
                    dvld_d    = 1'b0;
                    dsel_d    = '0;
                    state_d   = (mask_d == '0) ? RESP : SNOOP;
                end
            end
            SNOOP: begin
                ac_done_d = ac_done_q | (ac_fire & mask_q);
                cr_done_d = cr_done_q | cr_live;
                resp_d    = resp_q | merge_resp;
                if (!dvld_q && merge_dt_any) begin
                    dvld_d = 1'b1;
                    dsel_d = merge_dt_idx;
                end
                if (cr_done_d == mask_q) begin
                    state_d = RESP;
                end
`ifdef ACE_SNOOP_TIMEOUT_EN
                else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
                    resp_d[CrError] = 1'b1;
                    stale_ac_d      = stale_ac_d | (mask_q & ~ac_done_d);
                    stale_cr_d      = stale_cr_d | (mask_q & ~cr_done_d);
                    state_d         = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            snoop_q   <= '0;
            mask_q    <= '0;
            ac_done_q <= '0;
            cr_done_q <= '0;
            resp_q    <= '0;
            dvld_q    <= 1'b0;
            dsel_q    <= '0;
`ifdef ACE_SNOOP_TIMEOUT_EN
            cnt_q      <= '0;
            stale_ac_q <= '0;
            stale_cr_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            snoop_q   <= snoop_d;
            mask_q    <= mask_d;
            ac_done_q <= ac_done_d;
            cr_done_q <= cr_done_d;
            resp_q    <= resp_d;
            dvld_q    <= dvld_d;
            dsel_q    <= dsel_d;
`ifdef ACE_SNOOP_TIMEOUT_EN
            cnt_q      <= cnt_d;
            stale_ac_q <= stale_ac_d;
            stale_cr_q <= stale_cr_d;
`endif
        end
    end

    assign ac_addr_o      = addr_q;
    assign ac_snoop_o     = snoop_q;
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_resp_o     = resp_q;
    assign rsp_data_vld_o = dvld_q;
    assign rsp_data_sel_o = dsel_q;

endmodule

// File: tb/tb_ace_snoop_bcast.sv
// Directed bench for ace_snoop_bcast (4 ports, initiator excluded). The timeout
// scenario is included when ACE_SNOOP_TIMEOUT_EN is defined.
module tb_ace_snoop_bcast;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [63:0] req_addr_i;
    logic [3:0]  req_snoop_i;
    logic [1:0]  req_src_i;
    logic [3:0]  ac_valid_o;
    logic [3:0]  ac_ready_i;
    logic [63:0] ac_addr_o;
    logic [3:0]  ac_snoop_o;
    logic [3:0]  cr_valid_i;
    logic [3:0]  cr_ready_o;
    logic [19:0] cr_resp_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [4:0]  rsp_resp_o;
    logic        rsp_data_vld_o;
    logic [1:0]  rsp_data_sel_o;

    int n_checks = 0;
    int n_errors = 0;

    ace_snoop_bcast #(
        .NoSnoopPorts  (4),
        .AddrWidth     (64),
        .ExcludeSrc    (1'b1),
        .TimeoutCycles (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_addr_i     (req_addr_i),
        .req_snoop_i    (req_snoop_i),
        .req_src_i      (req_src_i),
        .ac_valid_o     (ac_valid_o),
        .ac_ready_i     (ac_ready_i),
        .ac_addr_o      (ac_addr_o),
        .ac_snoop_o     (ac_snoop_o),
        .cr_valid_i     (cr_valid_i),
        .cr_ready_o     (cr_ready_o),
        .cr_resp_i      (cr_resp_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_resp_o     (rsp_resp_o),
        .rsp_data_vld_o (rsp_data_vld_o),
        .rsp_data_sel_o (rsp_data_sel_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Minimum-latency transaction; entered and left at a negedge with the DUT idle.
    task automatic run_txn(input logic [1:0] src, input logic [63:0] addr, input logic [3:0] snp,
                           input logic [19:0] resp, input logic [3:0] exp_mask,
                           input logic [4:0] exp_resp, input logic exp_dvld, input logic [1:0] exp_sel);
        check("txn_req_ready", req_ready_o, 1);
        req_valid_i = 1'b1; req_addr_i = addr; req_snoop_i = snp; req_src_i = src;
        ac_ready_i = 4'hf; cr_valid_i = 4'h0; rsp_ready_i = 1'b0;
        @(negedge clk_i);
        check("txn_ac_valid", ac_valid_o, exp_mask);
        check("txn_ac_addr", ac_addr_o, addr);
        check("txn_ac_snoop", ac_snoop_o, snp);
        check("txn_cr_ready_early", cr_ready_o, 0);
        req_valid_i = 1'b0; cr_valid_i = exp_mask; cr_resp_i = resp;
        @(negedge clk_i);
        check("txn_ac_valid_done", ac_valid_o, 0);
        check("txn_cr_ready", cr_ready_o, exp_mask);
        @(negedge clk_i);
        check("txn_rsp_valid", rsp_valid_o, 1);
        check("txn_rsp_resp", rsp_resp_o, exp_resp);
        check("txn_data_vld", rsp_data_vld_o, exp_dvld);
        check("txn_data_sel", rsp_data_sel_o, exp_sel);
        cr_valid_i = 4'h0; rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("txn_rsp_done", rsp_valid_o, 0);
        rsp_ready_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        req_valid_i = 1'b0; req_addr_i = '0; req_snoop_i = '0; req_src_i = '0;
        ac_ready_i = 4'hf; cr_valid_i = '0; cr_resp_i = '0; rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Reset state
        check("rst_req_ready", req_ready_o, 1);
        check("rst_ac_valid", ac_valid_o, 0);
        check("rst_cr_ready", cr_ready_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_resp", rsp_resp_o, 0);
        check("rst_data_vld", rsp_data_vld_o, 0);
        check("rst_data_sel", rsp_data_sel_o, 0);
        check("rst_ac_addr", ac_addr_o, 0);
        check("rst_ac_snoop", ac_snoop_o, 0);

        // Source 1 excluded, null responses, response at cycle 3
        run_txn(2'd1, 64'h0000_1000_0000_0040, 4'h1, 20'h0, 4'b1101, 5'b00000, 1'b0, 2'd0);

        // Port 2 answers first, then ports 3 and 0 together with DataTransfer
        req_valid_i = 1'b1; req_addr_i = 64'hdead_beef_0000_0080; req_snoop_i = 4'h7; req_src_i = 2'd1;
        @(negedge clk_i);
        check("t2_ac_valid", ac_valid_o, 4'b1101);
        req_valid_i = 1'b0; cr_valid_i = 4'b0100; cr_resp_i = 20'h0;
        @(negedge clk_i);
        check("t2_cr_ready_all", cr_ready_o, 4'b1101);
        @(negedge clk_i);
        check("t2_cr_ready_left", cr_ready_o, 4'b1001);
        check("t2_rsp_early", rsp_valid_o, 0);
        cr_valid_i = 4'b1001; cr_resp_i = {5'b00101, 5'b00000, 5'b00000, 5'b01001};
        @(negedge clk_i);
        check("t2_rsp_valid", rsp_valid_o, 1);
        check("t2_rsp_resp", rsp_resp_o, 5'b01101);
        check("t2_data_vld", rsp_data_vld_o, 1);
        check("t2_data_sel", rsp_data_sel_o, 2'd0);
        cr_valid_i = 4'h0; rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;

        // First recorded data source wins over a lower index arriving later
        req_valid_i = 1'b1; req_addr_i = 64'h40; req_snoop_i = 4'h2; req_src_i = 2'd0;
        @(negedge clk_i);
        check("t2b_ac_valid", ac_valid_o, 4'b1110);
        req_valid_i = 1'b0; cr_valid_i = 4'b0100; cr_resp_i = {5'b0, 5'b00001, 5'b0, 5'b0};
        @(negedge clk_i);
        @(negedge clk_i);
        check("t2b_cr_ready_left", cr_ready_o, 4'b1010);
        cr_valid_i = 4'b1010; cr_resp_i = {5'b0, 5'b0, 5'b10001, 5'b0};
        @(negedge clk_i);
        check("t2b_rsp_resp", rsp_resp_o, 5'b10001);
        check("t2b_data_sel", rsp_data_sel_o, 2'd2);
        cr_valid_i = 4'h0; rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;

        // Port 2 stalls its AC for 10 cycles
        req_valid_i = 1'b1; req_addr_i = 64'h1234_5678_9abc_def0; req_snoop_i = 4'h9; req_src_i = 2'd3;
        ac_ready_i = 4'b1011;
        @(negedge clk_i);
        req_valid_i = 1'b0; cr_valid_i = 4'b0111; cr_resp_i = {5'b0, 5'b00001, 5'b0, 5'b0};
        for (int k = 0; k < 10; k++) begin
            check("t3_ac_valid2", ac_valid_o[2], 1);
            check("t3_ac_addr", ac_addr_o, 64'h1234_5678_9abc_def0);
            check("t3_cr_ready2", cr_ready_o[2], 0);
            if (k < 9) @(negedge clk_i);
        end
        ac_ready_i = 4'hf;
        @(negedge clk_i);
        check("t3_cr_ready2_after", cr_ready_o, 4'b0100);
        check("t3_rsp_early", rsp_valid_o, 0);
        @(negedge clk_i);
        cr_valid_i = 4'h0;

        // Response held 5 cycles with a new request waiting
        req_valid_i = 1'b1; req_addr_i = 64'hc0; req_snoop_i = 4'h3; req_src_i = 2'd2;
        for (int k = 0; k < 5; k++) begin
            check("t4_rsp_valid", rsp_valid_o, 1);
            check("t4_rsp_resp", rsp_resp_o, 5'b00001);
            check("t4_data_sel", rsp_data_sel_o, 2'd2);
            check("t4_req_ready", req_ready_o, 0);
            if (k < 4) @(negedge clk_i);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("t4_rsp_done", rsp_valid_o, 0);
        check("t4_req_ready_back", req_ready_o, 1);
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        check("t4_new_ac_valid", ac_valid_o, 4'b1011);
        check("t4_new_ac_addr", ac_addr_o, 64'hc0);
        req_valid_i = 1'b0; cr_valid_i = 4'b1011; cr_resp_i = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        check("t4_new_rsp", rsp_valid_o, 1);
        cr_valid_i = 4'h0; rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;

        // Asynchronous reset while snooping
        req_valid_i = 1'b1; req_addr_i = 64'h100; req_snoop_i = 4'h1; req_src_i = 2'd1;
        ac_ready_i = 4'h0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        check("t5_ac_valid_pre", ac_valid_o, 4'b1101);
        #2 rst_ni = 1'b0;
        #1;
        check("t5_ac_valid_rst", ac_valid_o, 0);
        check("t5_cr_ready_rst", cr_ready_o, 0);
        check("t5_rsp_valid_rst", rsp_valid_o, 0);
        check("t5_ac_addr_rst", ac_addr_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1; ac_ready_i = 4'hf;
        @(negedge clk_i);
        check("t5_req_ready", req_ready_o, 1);
        run_txn(2'd0, 64'h200, 4'h4, {5'b0, 5'b01000, 5'b0, 5'b0}, 4'b1110, 5'b01000, 1'b0, 2'd0);

`ifdef ACE_SNOOP_TIMEOUT_EN
        // Port 0 takes the AC but never returns CR
        req_valid_i = 1'b1; req_addr_i = 64'h300; req_snoop_i = 4'h1; req_src_i = 2'd1;
        @(negedge clk_i);
        req_valid_i = 1'b0; cr_valid_i = 4'b1100; cr_resp_i = '0;
        repeat (15) @(negedge clk_i);
        check("t6_rsp_before_to", rsp_valid_o, 0);
        @(negedge clk_i);
        check("t6_rsp_valid_to", rsp_valid_o, 1);
        check("t6_rsp_err", rsp_resp_o, 5'b00010);
        check("t6_stale_cr_ready", cr_ready_o, 4'b0001);
        cr_valid_i = 4'h0; rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check("t6_req_ready", req_ready_o, 1);
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_addr_i = 64'h340; req_src_i = 2'd3;
        @(negedge clk_i);
        check("t6_masked_ac", ac_valid_o, 4'b0110);
        check("t6_drain_ready", cr_ready_o, 4'b0001);
        req_valid_i = 1'b0; cr_valid_i = 4'b0111; cr_resp_i = {5'b0, 5'b0, 5'b0, 5'b11111};
        @(negedge clk_i);
        check("t6_cr_ready", cr_ready_o, 4'b0110);
        @(negedge clk_i);
        check("t6_rsp_valid", rsp_valid_o, 1);
        check("t6_rsp_discard", rsp_resp_o, 5'b00000);
        cr_valid_i = 4'h0; rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        run_txn(2'd3, 64'h380, 4'h1, 20'h0, 4'b0111, 5'b00000, 1'b0, 2'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ace_snoop_bcast.md
Name: ace_snoop_bcast

Overview:
- Parametrised ACE snoop broadcaster for the CCU.
- Takes one snoop request (address, AC snoop type, initiating port), broadcasts it on the AC channel to NoSnoopPorts cached masters (optionally excluding the initiator), collects every CR response, merges them and returns one aggregated response plus the index of the port supplying data.
- Sits between the CCU transaction decoder and the per-master snoop interfaces.
- One snoop outstanding at a time.

Parameters:
- NoSnoopPorts, 4, number of snooped masters (>=1).
- AddrWidth, 64, snoop address width.
- ExcludeSrc, 1, 1 = never snoop the initiating port.
- TimeoutCycles, 1024, snoop timeout in cycles; used only with the optional feature.
- IdxWidth, $clog2(NoSnoopPorts) (min 1), derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  snoop request valid.
- req_ready_o  out  1  request accepted.
- req_addr_i  in  AddrWidth  snoop address.
- req_snoop_i  in  4  acsnoop_t type.
- req_src_i  in  IdxWidth  initiating port index.
- ac_valid_o  out  NoSnoopPorts  per-port AC valid.
- ac_ready_i  in  NoSnoopPorts  per-port AC ready.
- ac_addr_o  out  AddrWidth  shared AC address.
- ac_snoop_o  out  4  shared AC snoop type.
- cr_valid_i  in  NoSnoopPorts  per-port CR valid.
- cr_ready_o  out  NoSnoopPorts  per-port CR ready.
- cr_resp_i  in  5*NoSnoopPorts  per-port crresp_t, port i at bits [5i+4:5i].
- rsp_valid_o  out  1  aggregated response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_resp_o  out  5  merged crresp_t.
- rsp_data_vld_o  out  1  some port transfers data.
- rsp_data_sel_o  out  IdxWidth  lowest-index port with DataTransfer set.

Behaviour:
- Interface: one clock (clk_i); reset rst_ni is asynchronous and active-low.
- crresp_t bit assignment: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique.
- FSM states: IDLE, SNOOP, RESP. Reset state is IDLE; all registers clear.
- Reset values: ac_valid_o=0, cr_ready_o=0, rsp_valid_o=0, rsp_resp_o=0, rsp_data_vld_o=0, rsp_data_sel_o=0, ac_addr_o=0, ac_snoop_o=0. req_ready_o=1, since it is (state==IDLE).
- IDLE, on req_valid_i&req_ready_o:
  - Latch address and snoop type.
  - mask = all ones, with bit req_src_i cleared if ExcludeSrc.
  - Clear ac_done, cr_done and the merge accumulator.
  - mask==0 (NoSnoopPorts=1 with exclusion) -> RESP with resp=0. Otherwise -> SNOOP.
- SNOOP, AC side:
  - ac_valid_o[i] = mask[i] & ~ac_done[i].
  - Once asserted, valid and payload stay stable until the handshake.
  - Ports handshake independently, in any order or cycle.
- SNOOP, CR side:
  - cr_ready_o[i] = ac_done[i] & ~cr_done[i]. A CR is never accepted before its own AC handshake.
  - The AC and CR handshake of different ports may occur in the same cycle.
  - On each CR handshake: resp_acc |= cr_resp_i[i].
  - If DataTransfer is set and no data source is recorded yet, record the lowest such index (ties within one cycle resolve to the lowest index).
- SNOOP -> RESP when (cr_done | accepted-this-cycle) == mask. Merged value is registered.
- RESP: rsp_valid_o=1, outputs stable until rsp_ready_i; then -> IDLE.
- Minimum latency: req handshake at cycle 0, AC at cycle 1, CR at cycle 2, rsp_valid_o at cycle 3.
- A back-to-back request is accepted the cycle after the response handshake.
- Reset mid-operation: everything returns to IDLE immediately; in-flight AC/CR are dropped.

Optional Feature:
- Macro: ACE_SNOOP_TIMEOUT_EN.
- Defined:
  - A counter runs in SNOOP. When it reaches TimeoutCycles-1:
    - Force the Error bit in the merged response.
    - Record the unresponded ports (mask & ~cr_done) in a stale register.
    - Go to RESP.
  - Ports that never completed AC keep ac_valid_o asserted until their handshake.
  - For stale ports, cr_ready_o=1 and the eventual CR is discarded.
  - Stale ports are removed from new broadcast masks until drained.
- Undefined: no counter, no stale logic; SNOOP waits indefinitely.

Decomposition:
- Add to ace_pkg:
  - acsnoop_t (logic[3:0]).
  - crresp_t (logic[4:0]) plus its bit-index constants.
  - the snoop-FSM state enum.
- Sub-module: ace_crresp_merge, combinational. OR-reduces the accepted CR responses and provides a lowest-index DataTransfer priority encoder.

Test Plan:
- N=4, src=1, ExcludeSrc=1, all ready, CR resp 0 -> AC on ports {0,2,3} only; rsp_resp_o=0, rsp_data_vld_o=0, rsp_valid_o at cycle 3.
- Port 3 CR=5'b00101, port 0 CR=5'b01001, both in the same cycle -> rsp_resp_o=5'b01101, rsp_data_sel_o=0.
- Port 2 ac_ready_i held low for 10 cycles -> ac_valid_o[2] stable for 10 cycles with constant address; no CR accepted from port 2 before its AC handshake.
- rsp_ready_i low for 5 cycles -> response held stable; req_ready_o=0 throughout; a new request is accepted the cycle after the response handshake.
- rst_ni pulsed low while in SNOOP -> all valids 0 asynchronously; req_ready_o=1 after release.
- ACE_SNOOP_TIMEOUT_EN, TimeoutCycles=16, port 0 never responds -> response at cycle 17 with Error=1; the next request masks out port 0 until its late CR is drained.
